ifetch_q: RTL and testbench
===========================

Name: ifetch_q

Overview:
- Parametrised successor to the single-slot instruction fetch stage.
- Fetches instructions from the ICache with one outstanding request, and steers the PC with predictor input and ROB redirects.
- Buffers fetched instructions, with their PC and predicted-taken bit, in an instruction queue of IQ_DEPTH entries. The queue decouples fetch from decoder stalls.
- Sits between the ICache and the decoder; the ROB drives the redirect.

Parameters:
ADDR_W, 32, PC/address width
INSTR_W, 32, instruction width
IQ_DEPTH, 8, instruction-queue entries (power of two, >=2)
RESET_PC, 0, PC after reset
PC_STEP, 4, sequential PC increment

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
rdy  in  1  global enable; 0 freezes all state
jump_wrong  in  1  ROB redirect (misprediction)
jump_pc  in  ADDR_W  redirect target
icache_enable  out  1  fetch request valid
pc_to_fetch  out  ADDR_W  fetch address
icache_success  in  1  response valid, one pulse per request
instr_fetched  in  INSTR_W  response data
is_jump_instr  in  1  predictor: instr_fetched is a branch/jump (same cycle as icache_success)
jump_prediction  in  1  predictor: taken
predict_jump_pc  in  ADDR_W  predicted target
stall_IF  in  1  decoder/LSB/ROB cannot accept this cycle
decoder_enable  out  1  instr_to_decode valid
instr_to_decode  out  INSTR_W  dequeued instruction
pc_to_decode  out  ADDR_W  its PC
pred_taken_to_decode  out  1  its prediction (is_jump_instr && jump_prediction)
iq_count  out  $clog2(IQ_DEPTH)+1  queue occupancy

Behaviour:
- Reset (rst=0, async): state IDLE, pc=RESET_PC, queue pointers and count 0.
  - Outputs: icache_enable 0, pc_to_fetch RESET_PC, decoder_enable 0, instr_to_decode 0, pc_to_decode 0, pred_taken_to_decode 0, iq_count 0.
- rdy=0: every register holds; all inputs ignored, including jump_wrong and icache_success.
- ICache protocol:
  - icache_enable = (state==WAIT); pc_to_fetch = pc.
  - A request is taken in the first enabled cycle, and in the cycle after any icache_success while enable stays high.
  - Address and enable hold stable until icache_success.
  - The cache returns exactly one icache_success per request, at any latency >=1.
- FSM states IDLE, WAIT, DROP. All transitions assume rdy=1 and jump_wrong=0 unless stated.
  - IDLE: if iq_count<IQ_DEPTH -> WAIT; else stay.
  - WAIT, no icache_success: stay.
  - WAIT, icache_success:
    - Push {instr_fetched, pc, taken} at the tail.
    - Next pc = predict_jump_pc if taken, else pc+PC_STEP (mod 2^ADDR_W).
    - Stay WAIT (back-to-back) if occupancy after this edge's push/pop < IQ_DEPTH; else -> IDLE.
  - DROP: icache_enable=0. On icache_success, discard the data and go -> IDLE.
- Redirect (jump_wrong=1, rdy=1), highest priority:
  - Queue flushed (count 0, pointers 0); no push or pop this edge; decoder_enable<=0; pc<=jump_pc.
  - IDLE -> IDLE; the first request for jump_pc goes out on the next cycle.
  - WAIT without same-cycle success -> DROP.
  - WAIT with same-cycle success -> IDLE; the response is discarded.
  - DROP -> DROP.
- Dequeue (registered, 1 entry/cycle):
  - If !stall_IF && count>0: drive the head onto the decode outputs, decoder_enable<=1, pop.
  - Otherwise decoder_enable<=0; the data outputs hold.
- Latency: icache_success at edge N writes the entry; earliest decoder_enable=1 is after edge N+1.
- Simultaneous push and pop: count unchanged. Pointers wrap modulo IQ_DEPTH.
- No push into a full queue is possible: a request is only issued or continued when a slot is guaranteed.

Test Plan:
- Reset with RESET_PC=0x100, 1-cycle cache, stall_IF=0, no jumps:
  - pc_to_fetch steps 0x100, 0x104, 0x108… with no bubbles after the first response.
  - decoder sees the same PCs in order, the first 2 cycles after its icache_success.
- stall_IF=1 held, 1-cycle cache:
  - Exactly IQ_DEPTH(8) pushes, then iq_count=8, state IDLE, icache_enable=0.
  - Release stall: 8 entries dequeue in order, one per cycle, and fetch resumes.
- Predicted taken: response at pc 0x104 with is_jump_instr=1, jump_prediction=1, predict_jump_pc=0x200 -> next pc_to_fetch=0x200; entry carries pred_taken=1.
- jump_wrong with jump_pc=0x400 while WAIT with a 3-cycle cache:
  - Queue flushed, icache_enable drops, the late response is discarded.
  - Next request is 0x400; no stale instruction reaches the decoder.
- jump_wrong in the same cycle as icache_success -> response dropped, iq_count=0, next request 0x400.
- rdy=0 for 3 cycles mid-WAIT with icache_success pulsing -> no state change; rst=0 asynchronously mid-fetch -> all outputs reset immediately.

Source files
------------

// File: rtl/ifetch_q.sv
// Instruction fetch stage: one outstanding ICache request, PC steered by predictor and ROB
// redirects, fetched instructions buffered in an IQ_DEPTH-entry queue toward the decoder.
module ifetch_q #(
    parameter int unsigned         ADDR_W   = 32,
    parameter int unsigned         INSTR_W  = 32,
    parameter int unsigned         IQ_DEPTH = 8,
    parameter logic [ADDR_W-1:0]   RESET_PC = '0,
    parameter int unsigned         PC_STEP  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rdy,
    input  logic                        jump_wrong,
    input  logic [ADDR_W-1:0]           jump_pc,
    output logic                        icache_enable,
    output logic [ADDR_W-1:0]           pc_to_fetch,
    input  logic                        icache_success,
    input  logic [INSTR_W-1:0]          instr_fetched,
    input  logic                        is_jump_instr,
    input  logic                        jump_prediction,
    input  logic [ADDR_W-1:0]           predict_jump_pc,
    input  logic                        stall_IF,
    output logic                        decoder_enable,
    output logic [INSTR_W-1:0]          instr_to_decode,
    output logic [ADDR_W-1:0]           pc_to_decode,
    output logic                        pred_taken_to_decode,
    output logic [$clog2(IQ_DEPTH):0]   iq_count
);

    localparam int unsigned PTR_W = $clog2(IQ_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DROP = 2'd2;

    localparam logic [CNT_W-1:0]  FULL = CNT_W'(IQ_DEPTH);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    logic [1:0]         state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               dec_en_q, dec_en_d;
    logic [INSTR_W-1:0] dec_instr_q, dec_instr_d;
    logic [ADDR_W-1:0]  dec_pc_q, dec_pc_d;
    logic               dec_taken_q, dec_taken_d;

    logic [INSTR_W-1:0] iq_instr_q [IQ_DEPTH];
    logic [ADDR_W-1:0]  iq_pc_q    [IQ_DEPTH];
    logic [IQ_DEPTH-1:0] iq_taken_q;

    logic               taken;
    logic               push;
    logic               pop;
    logic [CNT_W-1:0]   count_after;

    assign taken       = is_jump_instr & jump_prediction;
    assign push        = (state_q == WAIT) && icache_success && !jump_wrong;
    assign pop         = !jump_wrong && !stall_IF && (count_q != '0);
    assign count_after = count_q + CNT_W'(push) - CNT_W'(pop);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        dec_en_d    = 1'b0;
        dec_instr_d = dec_instr_q;
        dec_pc_d    = dec_pc_q;
        dec_taken_d = dec_taken_q;

        if (jump_wrong) begin
            // A redirect flushes everything; an in-flight request must still drain in DROP.
            pc_d    = jump_pc;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            if (state_q == WAIT) begin
                state_d = icache_success ? IDLE : DROP;
            end
        end else begin
            if (pop) begin
                dec_en_d    = 1'b1;
                dec_instr_d = iq_instr_q[head_q];
                dec_pc_d    = iq_pc_q[head_q];
                dec_taken_d = iq_taken_q[head_q];
                head_d      = head_q + 1'b1;
            end
            if (push) begin
                tail_d = tail_q + 1'b1;
            end
            count_d = count_after;

            unique case (state_q)
                IDLE: begin
                    if (count_q < FULL) state_d = WAIT;
                end
                WAIT: begin
                    if (icache_success) begin
                        pc_d    = taken ? predict_jump_pc : pc_q + STEP;
                        // Only keep fetching when the next response is guaranteed a slot.
                        state_d = (count_after < FULL) ? WAIT : IDLE;
                    end
                end
                DROP: begin
                    if (icache_success) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            dec_en_q    <= 1'b0;
            dec_instr_q <= '0;
            dec_pc_q    <= '0;
            dec_taken_q <= 1'b0;
        end else if (rdy) begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            dec_en_q    <= dec_en_d;
            dec_instr_q <= dec_instr_d;
            dec_pc_q    <= dec_pc_d;
            dec_taken_q <= dec_taken_d;
        end
    end

    // Queue storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (rdy && push) begin
            iq_instr_q[tail_q] <= instr_fetched;
            iq_pc_q[tail_q]    <= pc_q;
            iq_taken_q[tail_q] <= taken;
        end
    end

    assign icache_enable        = (state_q == WAIT);
    assign pc_to_fetch          = pc_q;
    assign decoder_enable       = dec_en_q;
    assign instr_to_decode      = dec_instr_q;
    assign pc_to_decode         = dec_pc_q;
    assign pred_taken_to_decode = dec_taken_q;
    assign iq_count             = count_q;

endmodule

// File: tb/tb_ifetch_q.sv
// Self-checking bench for ifetch_q: a directed vector table, hand-written corner sequences and
// a randomized run compared every cycle against a queue-based reference model.
module tb_ifetch_q;

    localparam int          DEPTH = 8;
    localparam logic [31:0] RPC   = 32'h100;

    logic        clk = 1'b0;
    logic        rst, rdy, jump_wrong, icache_success, is_jump_instr, jump_prediction, stall_IF;
    logic [31:0] jump_pc, instr_fetched, predict_jump_pc;
    logic        icache_enable, decoder_enable, pred_taken_to_decode;
    logic [31:0] pc_to_fetch, instr_to_decode, pc_to_decode;
    logic [3:0]  iq_count;

    always #5 clk = ~clk;

    ifetch_q #(
        .ADDR_W(32), .INSTR_W(32), .IQ_DEPTH(DEPTH), .RESET_PC(RPC), .PC_STEP(4)
    ) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .jump_wrong(jump_wrong), .jump_pc(jump_pc),
        .icache_enable(icache_enable), .pc_to_fetch(pc_to_fetch),
        .icache_success(icache_success), .instr_fetched(instr_fetched),
        .is_jump_instr(is_jump_instr), .jump_prediction(jump_prediction),
        .predict_jump_pc(predict_jump_pc), .stall_IF(stall_IF),
        .decoder_enable(decoder_enable), .instr_to_decode(instr_to_decode),
        .pc_to_decode(pc_to_decode), .pred_taken_to_decode(pred_taken_to_decode),
        .iq_count(iq_count)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of fetched entries plus request bookkeeping.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        taken;
    } ent_t;

    ent_t        m_q[$];
    ent_t        m_dec;
    logic [31:0] m_pc;
    bit          m_live, m_dead, m_dec_en;

    // Cache responder and stimulus knobs.
    bit pend;
    int lat_cnt, n_succ;
    int cfg_stall_pct, cfg_rdy_pct, cfg_jw_pct, cfg_lat_lo, cfg_lat_hi;
    bit cfg_pred, cfg_pulse;

    task automatic model_step();
        int   sz0;
        bit   tk;
        ent_t e;
        sz0 = m_q.size();
        tk  = is_jump_instr && jump_prediction;
        if (jump_wrong) begin
            m_q.delete();
            m_dec_en = 0;
            m_pc     = jump_pc;
            if (m_live) begin
                m_live = 0;
                m_dead = !icache_success;
            end
        end else begin
            if (!stall_IF && sz0 > 0) begin
                m_dec    = m_q.pop_front();
                m_dec_en = 1;
            end else begin
                m_dec_en = 0;
            end
            if (m_live && icache_success) begin
                e.instr = instr_fetched;
                e.pc    = m_pc;
                e.taken = tk;
                m_q.push_back(e);
                m_pc   = tk ? predict_jump_pc : m_pc + 32'd4;
                m_live = m_q.size() < DEPTH;
            end else if (m_dead) begin
                if (icache_success) m_dead = 0;
            end else if (!m_live && sz0 < DEPTH) begin
                m_live = 1;
            end
        end
    endtask

    // Drive one cycle's inputs (called just after a rising edge) and check at the falling edge.
    // jw_mode: 0 = no redirect, 1 = redirect to 0x400, 2 = random redirect.
    task automatic cyc_a(input int jw_mode);
        bit r, st, sc, jw;
        r  = ($urandom_range(99) < cfg_rdy_pct);
        st = ($urandom_range(99) < cfg_stall_pct);
        if (!pend && icache_enable) begin
            pend    = 1;
            lat_cnt = $urandom_range(cfg_lat_hi, cfg_lat_lo);
        end
        sc = (pend && lat_cnt == 1 && r) || (cfg_pulse && !r);
        jw = 0;
        if (jw_mode == 1) jw = 1;
        else if (jw_mode == 2) jw = ($urandom_range(99) < cfg_jw_pct) && !(m_dead && sc);
        rdy             = r;
        stall_IF        = st;
        icache_success  = sc;
        jump_wrong      = jw;
        jump_pc         = (jw_mode == 1) ? 32'h400 : ($urandom() & 32'hffff_fffc);
        instr_fetched   = $urandom();
        is_jump_instr   = cfg_pred ? 1'($urandom_range(1)) : 1'b0;
        jump_prediction = cfg_pred ? 1'($urandom_range(1)) : 1'b0;
        predict_jump_pc = $urandom() & 32'hffff_fffc;
        @(negedge clk);
        chk("icache_enable", icache_enable, m_live);
        chk("pc_to_fetch", pc_to_fetch, m_pc);
        chk("iq_count", iq_count, m_q.size());
        chk("decoder_enable", decoder_enable, m_dec_en);
        chk("instr_to_decode", instr_to_decode, m_dec.instr);
        chk("pc_to_decode", pc_to_decode, m_dec.pc);
        chk("pred_taken_to_decode", pred_taken_to_decode, m_dec.taken);
    endtask

    task automatic cyc_b();
        @(posedge clk);
        if (rdy) model_step();
        if (icache_success && rdy) begin
            pend = 0;
            n_succ++;
        end else if (pend && rdy && lat_cnt > 1) begin
            lat_cnt--;
        end
        #1;
    endtask

    task automatic tick(input int jw_mode);
        cyc_a(jw_mode);
        cyc_b();
    endtask

    task automatic do_reset();
        rst = 0; rdy = 1; jump_wrong = 0; jump_pc = '0; icache_success = 0;
        instr_fetched = '0; is_jump_instr = 0; jump_prediction = 0;
        predict_jump_pc = '0; stall_IF = 0;
        m_q.delete(); m_pc = RPC; m_live = 0; m_dead = 0; m_dec_en = 0; m_dec = '0;
        pend = 0; lat_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset icache_enable", icache_enable, 0);
        chk("reset pc_to_fetch", pc_to_fetch, RPC);
        chk("reset decoder_enable", decoder_enable, 0);
        chk("reset instr_to_decode", instr_to_decode, 0);
        chk("reset pc_to_decode", pc_to_decode, 0);
        chk("reset pred_taken", pred_taken_to_decode, 0);
        chk("reset iq_count", iq_count, 0);
        rst = 1;
    endtask

    typedef struct {
        bit          succ;
        logic [31:0] instr;
        bit          isj, prd;
        logic [31:0] ppc;
        bit          e_en;
        logic [31:0] e_pc;
        int          e_cnt;
        bit          e_dec;
        logic [31:0] e_dpc, e_di;
        bit          e_dtk;
    } vec_t;

    function automatic vec_t mkv(bit s, logic [31:0] ins, bit isj, bit prd, logic [31:0] ppc,
                                 bit en, logic [31:0] pc, int cnt, bit dec,
                                 logic [31:0] dpc, logic [31:0] di, bit dtk);
        vec_t v;
        v.succ = s; v.instr = ins; v.isj = isj; v.prd = prd; v.ppc = ppc;
        v.e_en = en; v.e_pc = pc; v.e_cnt = cnt; v.e_dec = dec;
        v.e_dpc = dpc; v.e_di = di; v.e_dtk = dtk;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vec_t        vt[7];
        bit          seen_en, got, found;
        logic [31:0] snap_pc;
        logic [3:0]  snap_cnt;

        cfg_stall_pct = 0; cfg_rdy_pct = 100; cfg_jw_pct = 0;
        cfg_lat_lo = 1; cfg_lat_hi = 1; cfg_pred = 0; cfg_pulse = 0; n_succ = 0;

        // 1-cycle cache, no stalls, a predicted-taken branch at 0x104.
        vt[0] = mkv(0, 32'h0,  0, 0, 32'h0,   0, 32'h100, 0, 0, 32'h0,   32'h0,  0);
        vt[1] = mkv(1, 32'hA0, 0, 0, 32'h0,   1, 32'h100, 0, 0, 32'h0,   32'h0,  0);
        vt[2] = mkv(1, 32'hA1, 1, 1, 32'h200, 1, 32'h104, 1, 0, 32'h0,   32'h0,  0);
        vt[3] = mkv(1, 32'hA2, 1, 0, 32'h300, 1, 32'h200, 1, 1, 32'h100, 32'hA0, 0);
        vt[4] = mkv(0, 32'h0,  0, 0, 32'h0,   1, 32'h204, 1, 1, 32'h104, 32'hA1, 1);
        vt[5] = mkv(0, 32'h0,  0, 0, 32'h0,   1, 32'h204, 0, 1, 32'h200, 32'hA2, 0);
        vt[6] = mkv(0, 32'h0,  0, 0, 32'h0,   1, 32'h204, 0, 0, 32'h200, 32'hA2, 0);

        do_reset();
        for (int i = 0; i < 7; i++) begin
            icache_success  = vt[i].succ;
            instr_fetched   = vt[i].instr;
            is_jump_instr   = vt[i].isj;
            jump_prediction = vt[i].prd;
            predict_jump_pc = vt[i].ppc;
            @(negedge clk);
            chk($sformatf("vec%0d icache_enable", i), icache_enable, vt[i].e_en);
            chk($sformatf("vec%0d pc_to_fetch", i), pc_to_fetch, vt[i].e_pc);
            chk($sformatf("vec%0d iq_count", i), iq_count, vt[i].e_cnt);
            chk($sformatf("vec%0d decoder_enable", i), decoder_enable, vt[i].e_dec);
            chk($sformatf("vec%0d pc_to_decode", i), pc_to_decode, vt[i].e_dpc);
            chk($sformatf("vec%0d instr_to_decode", i), instr_to_decode, vt[i].e_di);
            chk($sformatf("vec%0d pred_taken", i), pred_taken_to_decode, vt[i].e_dtk);
            @(posedge clk);
            #1;
        end

        // Stalled decoder: queue fills to DEPTH, fetch parks, then drains in order.
        do_reset();
        cfg_stall_pct = 100; n_succ = 0;
        repeat (16) tick(0);
        chk("full push count", n_succ, DEPTH);
        chk("full iq_count", iq_count, DEPTH);
        chk("full icache_enable", icache_enable, 0);
        chk("full pc_to_fetch", pc_to_fetch, 32'h120);
        cfg_stall_pct = 0;
        tick(0);
        seen_en = 0;
        for (int k = 0; k < DEPTH; k++) begin
            cyc_a(0);
            chk($sformatf("drain%0d decoder_enable", k), decoder_enable, 1);
            chk($sformatf("drain%0d pc_to_decode", k), pc_to_decode, 32'h100 + 4 * k);
            if (icache_enable) seen_en = 1;
            cyc_b();
        end
        chk("fetch resumes after drain", seen_en, 1);

        // Redirect while a 3-cycle request is in flight.
        do_reset();
        cfg_stall_pct = 100; cfg_lat_lo = 3; cfg_lat_hi = 3;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (pend && lat_cnt == 2 && m_live && m_q.size() > 0) found = 1;
            else tick(0);
        end
        chk("redirect window reached", found, 1);
        tick(1);
        cfg_stall_pct = 0;
        cyc_a(0);
        chk("redirect iq_count", iq_count, 0);
        chk("redirect icache_enable", icache_enable, 0);
        chk("redirect decoder_enable", decoder_enable, 0);
        chk("redirect pc_to_fetch", pc_to_fetch, 32'h400);
        cyc_b();
        seen_en = 0; got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            cyc_a(0);
            if (icache_enable && !seen_en) begin
                seen_en = 1;
                chk("first request after redirect", pc_to_fetch, 32'h400);
            end
            if (decoder_enable) begin
                got = 1;
                chk("first decode after redirect", pc_to_decode, 32'h400);
            end
            cyc_b();
        end
        chk("decode after redirect seen", got, 1);

        // Redirect in the same cycle as a response.
        do_reset();
        cfg_stall_pct = 100; cfg_lat_lo = 1; cfg_lat_hi = 1;
        repeat (4) tick(0);
        tick(1);
        cyc_a(0);
        chk("same-cycle iq_count", iq_count, 0);
        chk("same-cycle icache_enable", icache_enable, 0);
        chk("same-cycle pc_to_fetch", pc_to_fetch, 32'h400);
        cyc_b();
        cyc_a(0);
        chk("same-cycle next request enable", icache_enable, 1);
        chk("same-cycle next request pc", pc_to_fetch, 32'h400);
        cyc_b();

        // rdy low with spurious responses: nothing moves.
        do_reset();
        cfg_stall_pct = 0; cfg_lat_lo = 2; cfg_lat_hi = 2;
        repeat (5) tick(0);
        snap_pc = pc_to_fetch;
        snap_cnt = iq_count;
        cfg_rdy_pct = 0; cfg_pulse = 1;
        for (int i = 0; i < 3; i++) begin
            cyc_a(2);
            chk($sformatf("freeze%0d pc_to_fetch", i), pc_to_fetch, snap_pc);
            chk($sformatf("freeze%0d iq_count", i), iq_count, snap_cnt);
            chk($sformatf("freeze%0d icache_enable", i), icache_enable, 1);
            cyc_b();
        end
        cfg_rdy_pct = 100; cfg_pulse = 0; cfg_lat_lo = 1; cfg_lat_hi = 3;
        repeat (6) tick(0);

        // Asynchronous reset between clock edges.
        cyc_a(0);
        #2 rst = 0;
        #1;
        chk("async icache_enable", icache_enable, 0);
        chk("async pc_to_fetch", pc_to_fetch, RPC);
        chk("async decoder_enable", decoder_enable, 0);
        chk("async pc_to_decode", pc_to_decode, 0);
        chk("async iq_count", iq_count, 0);
        do_reset();

        // Randomized run against the model.
        cfg_stall_pct = 30; cfg_rdy_pct = 90; cfg_jw_pct = 3;
        cfg_lat_lo = 1; cfg_lat_hi = 4; cfg_pred = 1;
        repeat (3000) tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
